// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: 2-FF input synchroniser, mid-bit sampling, stop-bit check,
// valid/ready byte handoff with single-cycle framing-error and overrun pulses.
module uart_rx #(
   parameter int CYCLES_PER_BIT = 434,
   parameter int HALF_BIT       = 217
) (
   input  logic       i_clk_50M,
   input  logic       i_rst,
   input  logic       i_rx,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   input  logic       i_rx_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy
);

   // state  | meaning
   // IDLE   | line idle, waiting for a falling edge on rx_s
   // START  | timing to start-bit middle, rejecting glitches
   // DATA   | sampling 8 data bits at bit middles
   // STOP   | sampling stop bit, delivering or flagging the frame
   // BREAK  | line held low after a framing error; wait for idle
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   localparam logic [10:0] LP_BIT_LAST  = 11'(CYCLES_PER_BIT - 1);
   localparam logic [10:0] LP_HALF_LAST = 11'(HALF_BIT - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_rx_meta;
   logic        r_rx_s;
   logic [10:0] r_cnt;
   logic [10:0] w_cnt_nxt;
   logic [2:0]  r_idx;
   logic [2:0]  w_idx_nxt;
   logic [7:0]  r_shift;
   logic [7:0]  w_shift_nxt;
   logic        w_deliver;
   logic        w_frame_err;

   always_ff @(posedge i_clk_50M) begin
      if (i_rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge i_clk_50M) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 11'd1;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_deliver   = 1'b0;
      w_frame_err = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (!r_rx_s) w_state_nxt = S_START;
         end
         S_START: begin
            if (r_cnt == LP_HALF_LAST) begin
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == LP_BIT_LAST) begin
               w_cnt_nxt          = '0;
               w_shift_nxt[r_idx] = r_rx_s;
               if (r_idx == 3'd7) w_state_nxt = S_STOP;
               else               w_idx_nxt   = r_idx + 3'd1;
            end
         end
         S_STOP: begin
            if (r_cnt == LP_BIT_LAST) begin
               w_cnt_nxt = '0;
               // Back to IDLE at stop-bit middle so a following start edge is not missed.
               if (r_rx_s) begin
                  w_deliver   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_frame_err = 1'b1;
                  w_state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            w_cnt_nxt = '0;
            if (r_rx_s) w_state_nxt = S_IDLE;
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk_50M) begin
      if (i_rst) begin
         o_rx_data   <= '0;
         o_rx_valid  <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_frame_err <= w_frame_err;
         o_overrun   <= 1'b0;
         if (w_deliver) begin
            // A pending byte being accepted this cycle frees the slot for the new one.
            if (!o_rx_valid || i_rx_ready) begin
               o_rx_data  <= r_shift;
               o_rx_valid <= 1'b1;
            end else begin
               o_overrun <= 1'b1;
            end
         end else if (o_rx_valid && i_rx_ready) begin
            o_rx_valid <= 1'b0;
         end
      end
   end

   assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes, a negedge monitor pops and
// compares on every accepted byte and tracks error pulses.
module tb_uart_rx;
   localparam int CPB = 434;
   localparam int HB  = 217;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic       rdy = 1'b1;
   logic [7:0] o_rx_data;
   logic       o_rx_valid;
   logic       o_frame_err;
   logic       o_overrun;
   logic       o_busy;

   always #10 clk = ~clk;

   uart_rx #(.CYCLES_PER_BIT(CPB), .HALF_BIT(HB)) dut (
      .i_clk_50M  (clk),
      .i_rst      (rst),
      .i_rx       (rx),
      .o_rx_data  (o_rx_data),
      .o_rx_valid (o_rx_valid),
      .i_rx_ready (rdy),
      .o_frame_err(o_frame_err),
      .o_overrun  (o_overrun),
      .o_busy     (o_busy)
   );

   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   int         n_acc = 0;
   int         n_fe = 0;
   int         n_ov = 0;
   int         cyc = 0;
   int         t_fall = 0;
   int         last_rise = 0;
   logic       prev_valid = 1'b0;
   logic       prev_fe = 1'b0;
   logic       prev_ov = 1'b0;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (o_rx_valid && !prev_valid) last_rise = cyc;
         if (o_rx_valid && rdy) begin
            n_acc++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_byte actual=0x%0h required=none", o_rx_data);
            end else begin
               chk("rx_data", int'(o_rx_data), int'(exp_q.pop_front()));
            end
         end
         if (o_frame_err) begin
            n_fe++;
            chk("frame_err_width", int'(prev_fe), 0);
            chk("frame_err_overrun_excl", int'(o_overrun), 0);
         end
         if (o_overrun) begin
            n_ov++;
            chk("overrun_width", int'(prev_ov), 0);
         end
      end
      prev_valid = o_rx_valid;
      prev_fe    = o_frame_err;
      prev_ov    = o_overrun;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      rx     = 1'b0;
      t_fall = cyc;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop_v;
      tick(CPB);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rx_data"}, int'(o_rx_data), 0);
      chk({tag, "_rx_valid"}, int'(o_rx_valid), 0);
      chk({tag, "_frame_err"}, int'(o_frame_err), 0);
      chk({tag, "_overrun"}, int'(o_overrun), 0);
      chk({tag, "_busy"}, int'(o_busy), 0);
   endtask

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         acc0;
      int         fe0;
      int         ov0;
      int         lat;
      int         wait_n;
      logic [7:0] b77;

      rst = 1'b1; rx = 1'b1; rdy = 1'b1;
      tick(5);
      chk_reset_vals("reset");
      rst = 1'b0;
      tick(10);

      // 1: single byte, ready high, latency window
      acc0 = n_acc; fe0 = n_fe;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      tick(20);
      chk("t1_bytes", n_acc - acc0, 1);
      chk("t1_frame_err", n_fe - fe0, 0);
      chk("t1_valid_low", int'(o_rx_valid), 0);
      lat = last_rise - t_fall;
      checks++;
      if (lat < 4125 || lat > 4127) begin
         failures++;
         $display("FAIL t1_latency actual=%0d required=4125..4127", lat);
      end

      // 2: back-to-back frames
      acc0 = n_acc; fe0 = n_fe; ov0 = n_ov;
      exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h5A);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h5A, 1'b1);
      tick(20);
      chk("t2_bytes", n_acc - acc0, 3);
      chk("t2_frame_err", n_fe - fe0, 0);
      chk("t2_overrun", n_ov - ov0, 0);

      // 3: 100-cycle glitch
      acc0 = n_acc; fe0 = n_fe;
      rx = 1'b0;
      tick(50);
      chk("t3_busy_in_glitch", int'(o_busy), 1);
      tick(50);
      rx = 1'b1;
      tick(300);
      chk("t3_busy_after", int'(o_busy), 0);
      chk("t3_bytes", n_acc - acc0, 0);
      chk("t3_frame_err", n_fe - fe0, 0);

      // 4: framing error then break, then a clean frame
      acc0 = n_acc; fe0 = n_fe;
      send_frame(8'h3C, 1'b0);
      tick(2000);
      chk("t4_busy_in_break", int'(o_busy), 1);
      chk("t4_frame_err", n_fe - fe0, 1);
      chk("t4_no_byte", n_acc - acc0, 0);
      rx = 1'b1;
      tick(10);
      chk("t4_busy_after_break", int'(o_busy), 0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      tick(20);
      chk("t4_bytes", n_acc - acc0, 1);
      chk("t4_frame_err_total", n_fe - fe0, 1);

      // 5: overrun with ready low
      acc0 = n_acc; ov0 = n_ov;
      rdy = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      tick(20);
      chk("t5_valid_held", int'(o_rx_valid), 1);
      chk("t5_data_kept", int'(o_rx_data), 8'h11);
      chk("t5_overrun", n_ov - ov0, 1);
      chk("t5_no_accept", n_acc - acc0, 0);
      rdy = 1'b1;
      tick(2);
      chk("t5_valid_cleared", int'(o_rx_valid), 0);
      chk("t5_bytes", n_acc - acc0, 1);

      // 6: reset mid-frame with a byte pending
      acc0 = n_acc;
      rdy = 1'b0;
      send_frame(8'h42, 1'b1);
      tick(20);
      chk("t6_pending_valid", int'(o_rx_valid), 1);
      chk("t6_pending_data", int'(o_rx_data), 8'h42);
      b77 = 8'h77;
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = b77[i];
         tick(CPB);
      end
      rx = b77[4];
      tick(200);
      chk("t6_busy_before_rst", int'(o_busy), 1);
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      chk_reset_vals("t6_after_rst");
      rx = 1'b1;
      rdy = 1'b1;
      tick(1000);
      chk("t6_no_stale_byte", n_acc - acc0, 0);
      exp_q.push_back(8'h99);
      send_frame(8'h99, 1'b1);
      tick(20);
      chk("t6_bytes", n_acc - acc0, 1);

      wait_n = 0;
      while (exp_q.size() != 0 && wait_n < 2000) begin
         tick(1);
         wait_n++;
      end
      chk("final_queue_empty", exp_q.size(), 0);
      chk("final_frame_err_total", n_fe, 1);
      chk("final_overrun_total", n_ov, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
